// File: rtl/rv_ctrl_pkg.sv
// Shared control definitions for the RV32I control units.
// Contents: FSM state encodings, opcode constants, ImmSel/WBSel/AluSEL
// encodings, the decoded instruction-format enum, and the width helper
// used to size the memory-wait counter.
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    FMT_LUI,
    FMT_AUIPC,
    FMT_JAL,
    FMT_JALR,
    FMT_BRANCH,
    FMT_LOAD,
    FMT_STORE,
    FMT_OPIMM,
    FMT_OP,
    FMT_ILLEGAL
  } fmt_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  // Bits needed to hold values 0..limit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32I instruction decode, shared by the single-cycle and
// multicycle control units.
// Ports:
//   ir_i       latched instruction word
//   format_o   instruction class (FMT_ILLEGAL for non-RV32I opcodes)
//   imm_sel_o  immediate format
//   alu_sel_o  ALU operation {funct7[5], funct3}
//   wb_sel_o   writeback source
//   illegal_o  opcode is outside the supported RV32I set
module ctrl_decode
  import rv_ctrl_pkg::*;
(
  input  logic [31:0] ir_i,
  output fmt_e        format_o,
  output logic [2:0]  imm_sel_o,
  output logic [3:0]  alu_sel_o,
  output logic [1:0]  wb_sel_o,
  output logic        illegal_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b5;
  logic       unused_ir;

  assign opcode    = ir_i[6:0];
  assign funct3    = ir_i[14:12];
  assign f7b5      = ir_i[30];
  assign unused_ir = ^{ir_i[31], ir_i[29:15], ir_i[11:7]};

  always_comb begin
    format_o  = FMT_ILLEGAL;
    imm_sel_o = IMM_I;
    alu_sel_o = ALU_ADD;
    wb_sel_o  = WB_ALU;
    illegal_o = 1'b0;
    unique case (opcode)
      OPC_LUI: begin
        format_o  = FMT_LUI;
        imm_sel_o = IMM_U;
      end
      OPC_AUIPC: begin
        format_o  = FMT_AUIPC;
        imm_sel_o = IMM_U;
      end
      OPC_JAL: begin
        format_o  = FMT_JAL;
        imm_sel_o = IMM_J;
        wb_sel_o  = WB_PC4;
      end
      OPC_JALR: begin
        format_o  = FMT_JALR;
        wb_sel_o  = WB_PC4;
      end
      OPC_BRANCH: begin
        format_o  = FMT_BRANCH;
        imm_sel_o = IMM_B;
      end
      OPC_LOAD: begin
        format_o  = FMT_LOAD;
        wb_sel_o  = WB_MEM;
      end
      OPC_STORE: begin
        format_o  = FMT_STORE;
        imm_sel_o = IMM_S;
      end
      OPC_OPIMM: begin
        format_o  = FMT_OPIMM;
        // funct7[5] only distinguishes srai from srli; elsewhere it is immediate bits.
        alu_sel_o = (funct3 == 3'b101) ? {f7b5, funct3} : {1'b0, funct3};
      end
      OPC_OP: begin
        format_o  = FMT_OP;
        alu_sel_o = {f7b5, funct3};
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I control unit: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// Memory waits are bounded by TIMEOUT; an expired wait or an unsupported
// opcode enters a sticky TRAP state that only rst leaves.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   instr                instruction word (bits [31:0] decoded)
//   mem_ready            memory completion, honoured only in FETCH/MEM
//   BrEq, BrLT           branch comparator results
//   mem_req, IRWrite, PCWrite, RegWEn, MemRw   enables
//   PCSel, ALUsrc1, ALUsrc2, BrUn              datapath selects
//   ImmSel, AluSEL, ldU, WBSel                 decoded fields from ir
//   state_o              current FSM state
//   trap                 sticky fault flag
module multicycle_control
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned N       = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] instr,
  input  logic         mem_ready,
  input  logic         BrEq,
  input  logic         BrLT,
  output logic         mem_req,
  output logic         IRWrite,
  output logic         PCWrite,
  output logic         RegWEn,
  output logic         MemRw,
  output logic         PCSel,
  output logic         ALUsrc1,
  output logic         ALUsrc2,
  output logic         BrUn,
  output logic [2:0]   ImmSel,
  output logic [3:0]   AluSEL,
  output logic [2:0]   ldU,
  output logic [1:0]   WBSel,
  output logic [2:0]   state_o,
  output logic         trap
);

  localparam int unsigned CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [31:0]   ir_q, ir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          trap_q, trap_d;

  fmt_e fmt;
  logic illegal;
  logic br_taken;

  if (N > 32) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^instr[N-1:32];
  end

  ctrl_decode u_dec (
    .ir_i      (ir_q),
    .format_o  (fmt),
    .imm_sel_o (ImmSel),
    .alu_sel_o (AluSEL),
    .wb_sel_o  (WBSel),
    .illegal_o (illegal)
  );

  // funct3[2] picks lt/ge over eq/ne; funct3[0] inverts the sense.
  assign br_taken = (ir_q[14] ? BrLT : BrEq) ^ ir_q[12];

  assign ALUsrc1 = (fmt == FMT_AUIPC) || (fmt == FMT_JAL) || (fmt == FMT_BRANCH);
  assign ALUsrc2 = (fmt != FMT_OP) && (fmt != FMT_ILLEGAL);
  assign BrUn    = (fmt == FMT_BRANCH) && ir_q[13];
  assign ldU     = ir_q[14:12];
  assign state_o = state_q;
  assign trap    = trap_q;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    mem_req = 1'b0;
    IRWrite = 1'b0;
    PCWrite = 1'b0;
    PCSel   = 1'b0;
    RegWEn  = 1'b0;
    MemRw   = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          ir_d    = instr[31:0];
          state_d = S_DECODE;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DECODE: state_d = illegal ? S_TRAP : S_EXEC;
      S_EXEC: begin
        unique case (fmt)
          FMT_BRANCH: begin
            PCWrite = 1'b1;
            PCSel   = br_taken;
            state_d = S_FETCH;
          end
          FMT_JAL, FMT_JALR: begin
            PCWrite = 1'b1;
            PCSel   = 1'b1;
            state_d = S_WB;
          end
          FMT_LOAD, FMT_STORE: state_d = S_MEM;
          default:             state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        MemRw   = (fmt == FMT_STORE);
        if (mem_ready) begin
          if (fmt == FMT_STORE) begin
            PCWrite = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (cnt_q == WAIT_LAST) begin
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB: begin
        RegWEn  = 1'b1;
        PCWrite = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
    // Any state change restarts the wait count, so FETCH and MEM begin at zero.
    if (state_d != state_q) cnt_d = '0;
    trap_d = trap_q || (state_d == S_TRAP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      cnt_q   <= '0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      trap_q  <= trap_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        mem_ready = 1'b0;
  logic        BrEq = 1'b0;
  logic        BrLT = 1'b0;
  logic        mem_req, IRWrite, PCWrite, RegWEn, MemRw, PCSel;
  logic        ALUsrc1, ALUsrc2, BrUn, trap;
  logic [2:0]  ImmSel, ldU, state_o;
  logic [3:0]  AluSEL;
  logic [1:0]  WBSel;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_control #(.N(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
    .BrEq(BrEq), .BrLT(BrLT), .mem_req(mem_req), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWEn(RegWEn), .MemRw(MemRw), .PCSel(PCSel),
    .ALUsrc1(ALUsrc1), .ALUsrc2(ALUsrc2), .BrUn(BrUn), .ImmSel(ImmSel),
    .AluSEL(AluSEL), .ldU(ldU), .WBSel(WBSel), .state_o(state_o), .trap(trap)
  );

  // Instruction classes of the reference model.
  localparam int K_LUI = 0, K_AUIPC = 1, K_JAL = 2, K_JALR = 3, K_BR = 4;
  localparam int K_LD = 5, K_ST = 6, K_OPI = 7, K_OP = 8, K_BAD = 9;

  typedef struct {
    bit         legal;
    int         kind;
    logic [2:0] imm;
    logic [3:0] alu;
    logic [1:0] wb;
    logic       s1;
    logic       s2;
    logic       brun;
  } dec_t;

  // Expected decode straight from the instruction-set rules.
  function automatic dec_t model_dec(input logic [31:0] i);
    dec_t d;
    logic [2:0] f3;
    f3 = i[14:12];
    d.legal = 1; d.kind = K_BAD; d.imm = 3'd0; d.alu = 4'd0; d.wb = 2'd1;
    d.s1 = 0; d.s2 = 0; d.brun = 0;
    case (i[6:0])
      7'h37: begin d.kind = K_LUI;   d.imm = 3'd3; d.s2 = 1; end
      7'h17: begin d.kind = K_AUIPC; d.imm = 3'd3; d.s1 = 1; d.s2 = 1; end
      7'h6f: begin d.kind = K_JAL;   d.imm = 3'd4; d.s1 = 1; d.s2 = 1; d.wb = 2'd2; end
      7'h67: begin d.kind = K_JALR;  d.s2 = 1; d.wb = 2'd2; end
      7'h63: begin d.kind = K_BR;    d.imm = 3'd2; d.s1 = 1; d.s2 = 1; d.brun = f3[1]; end
      7'h03: begin d.kind = K_LD;    d.s2 = 1; d.wb = 2'd0; end
      7'h23: begin d.kind = K_ST;    d.imm = 3'd1; d.s2 = 1; end
      7'h13: begin
        d.kind = K_OPI; d.s2 = 1;
        d.alu = (f3 == 3'd5) ? {i[30], f3} : {1'b0, f3};
      end
      7'h33: begin d.kind = K_OP; d.alu = {i[30], f3}; end
      default: d.legal = 0;
    endcase
    return d;
  endfunction

  function automatic bit model_taken(input logic [2:0] f3, input bit eq, input bit lt);
    case (f3)
      3'd0: return eq;
      3'd1: return !eq;
      3'd4, 3'd6: return lt;
      default: return !lt;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cycle(input string tag, input int st, input bit mreq, input bit mrw,
                           input bit irw, input bit pcw, input bit pcs, input bit regw,
                           input bit trp);
    chk({tag, ".state"},   32'(state_o), 32'(st));
    chk({tag, ".mem_req"}, 32'(mem_req), 32'(mreq));
    chk({tag, ".MemRw"},   32'(MemRw),   32'(mrw));
    chk({tag, ".IRWrite"}, 32'(IRWrite), 32'(irw));
    chk({tag, ".PCWrite"}, 32'(PCWrite), 32'(pcw));
    chk({tag, ".PCSel"},   32'(PCSel),   32'(pcs));
    chk({tag, ".RegWEn"},  32'(RegWEn),  32'(regw));
    chk({tag, ".trap"},    32'(trap),    32'(trp));
  endtask

  task automatic chk_dec(input string tag, input dec_t d, input logic [31:0] ins);
    logic [2:0] f3;
    f3 = ins[14:12];
    chk({tag, ".ImmSel"},  32'(ImmSel),  32'(d.imm));
    chk({tag, ".AluSEL"},  32'(AluSEL),  32'(d.alu));
    chk({tag, ".WBSel"},   32'(WBSel),   32'(d.wb));
    chk({tag, ".ALUsrc1"}, 32'(ALUsrc1), 32'(d.s1));
    chk({tag, ".ALUsrc2"}, 32'(ALUsrc2), 32'(d.s2));
    chk({tag, ".BrUn"},    32'(BrUn),    32'(d.brun));
    chk({tag, ".ldU"},     32'(ldU),     32'(f3));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    tick();
    tick();
    #1;
    chk_cycle("reset", 0, 1, 0, 0, 0, 0, 0, 0);
    chk("reset.ALUsrc1", 32'(ALUsrc1), 32'd0);
    chk("reset.ALUsrc2", 32'(ALUsrc2), 32'd0);
    chk("reset.BrUn",    32'(BrUn),    32'd0);
    chk("reset.ImmSel",  32'(ImmSel),  32'd0);
    chk("reset.AluSEL",  32'(AluSEL),  32'd0);
    chk("reset.WBSel",   32'(WBSel),   32'd1);
    chk("reset.ldU",     32'(ldU),     32'd0);
    rst = 1'b0;
  endtask

  // Drives one whole instruction and checks every cycle of it.
  task automatic run_instr(input logic [31:0] ins, input int fdly, input int mdly,
                           input bit eq, input bit lt, input bit rst_in_mem,
                           output bit trapped);
    dec_t d;
    bit   st, done;
    d = model_dec(ins);
    st = (d.kind == K_ST);
    trapped = 0;
    done = 0;
    for (int k = 0; k <= fdly; k++) begin
      mem_ready = (k == fdly);
      instr = (k == fdly) ? ins : $urandom;
      #1;
      chk_cycle("fetch", 0, 1, 0, mem_ready, 0, 0, 0, 0);
      tick();
    end
    instr = $urandom;
    mem_ready = 1'($urandom);
    #1;
    chk_cycle("decode", 1, 0, 0, 0, 0, 0, 0, 0);
    if (d.legal) chk_dec("decode", d, ins);
    tick();
    if (!d.legal) begin
      for (int k = 0; k < 3; k++) begin
        mem_ready = 1'b1;
        #1;
        chk_cycle("trap", 5, 0, 0, 0, 0, 0, 0, 1);
        tick();
      end
      trapped = 1;
      done = 1;
    end
    if (!done) begin
      mem_ready = 1'($urandom);
      BrEq = eq;
      BrLT = lt;
      #1;
      if (d.kind == K_BR)
        chk_cycle("exec", 2, 0, 0, 0, 1, model_taken(ins[14:12], eq, lt), 0, 0);
      else if (d.kind == K_JAL || d.kind == K_JALR)
        chk_cycle("exec", 2, 0, 0, 0, 1, 1, 0, 0);
      else
        chk_cycle("exec", 2, 0, 0, 0, 0, 0, 0, 0);
      chk_dec("exec", d, ins);
      tick();
      if (d.kind == K_BR) done = 1;
    end
    if (!done && (d.kind == K_LD || st)) begin
      for (int k = 0; k <= mdly && !done; k++) begin
        mem_ready = (k == mdly);
        #1;
        chk_cycle("mem", 3, 1, st, 0, st && mem_ready, 0, 0, 0);
        chk_dec("mem", d, ins);
        if (rst_in_mem && k == 1) begin
          rst = 1'b1;
          tick();
          #1;
          chk("rstmem.state", 32'(state_o), 32'd0);
          chk("rstmem.MemRw", 32'(MemRw),   32'd0);
          chk("rstmem.trap",  32'(trap),    32'd0);
          rst = 1'b0;
          done = 1;
        end else begin
          tick();
        end
      end
      if (st) done = 1;
    end
    if (!done) begin
      mem_ready = 1'($urandom);
      #1;
      chk_cycle("wb", 4, 0, 0, 0, 1, 0, 1, 0);
      chk_dec("wb", d, ins);
      tick();
    end
  endtask

  logic [6:0] legal_ops [9] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
  logic [6:0] bad_ops   [4] = '{7'h7f, 7'h0f, 7'h73, 7'h00};
  logic [2:0] br_f3     [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

  initial begin
    bit          tr;
    logic [31:0] ins;
    logic [6:0]  op;

    do_reset();

    // addi with immediate memory response
    run_instr(32'h00400793, 0, 0, 0, 0, 0, tr);
    // sw with three wait cycles in MEM
    run_instr(32'hfef42623, 1, 3, 0, 0, 0, tr);
    // sub, then loads (lb and lw forms)
    run_instr(32'h40C58533, 0, 0, 0, 0, 0, tr);
    run_instr(32'h00458603, 0, 1, 0, 0, 0, tr);
    run_instr(32'h0045a603, 0, 2, 0, 0, 0, tr);
    chk("lw.ldU", 32'(ldU), 32'd2);
    // beq taken and not taken
    run_instr(32'h00058663, 0, 0, 1, 0, 0, tr);
    run_instr(32'h00058663, 2, 0, 0, 1, 0, tr);
    // jal, srai
    run_instr(32'h0080006f, 0, 0, 0, 0, 0, tr);
    run_instr(32'h4035d513, 0, 0, 0, 0, 0, tr);

    // reset in the middle of a store's MEM wait
    run_instr(32'hfef42623, 0, 3, 0, 0, 1, tr);
    chk("rstmem.ImmSel", 32'(ImmSel), 32'd0);

    // fetch timeout
    do_reset();
    for (int k = 0; k < 16; k++) begin
      mem_ready = 1'b0;
      #1;
      chk_cycle("tmo.wait", 0, 1, 0, 0, 0, 0, 0, 0);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      mem_ready = 1'b1;
      #1;
      chk_cycle("tmo.trap", 5, 0, 0, 0, 0, 0, 0, 1);
      tick();
    end

    // illegal instruction
    do_reset();
    run_instr(32'hFFFFFFFF, 0, 0, 0, 0, 0, tr);
    chk("illegal.trapped", 32'(tr), 32'd1);

    // randomized instruction stream
    do_reset();
    for (int n = 0; n < 150; n++) begin
      ins = $urandom;
      if ($urandom_range(0, 19) == 0) op = bad_ops[$urandom_range(0, 3)];
      else op = legal_ops[$urandom_range(0, 8)];
      ins[6:0] = op;
      if (op == 7'h63) ins[14:12] = br_f3[$urandom_range(0, 5)];
      run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom), 1'($urandom), 0, tr);
      if (tr) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
